adc_clip_monitor: RTL



---
 rtl/adc_clip_pkg.sv | 16 +
 rtl/adc_clip_win_ctr.sv | 33 +++
 rtl/adc_clip_monitor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/adc_clip_pkg.sv
// Shared types and default widths for the ADC clip monitor slice.
package adc_clip_pkg;

  localparam int unsigned DEF_WIN_WIDTH  = 16;
  localparam int unsigned DEF_CNT_WIDTH  = 16;
  localparam int unsigned DEF_CLR_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    BLANK,
    REPORT
  } clip_mon_state_t;

endpackage

// File: rtl/adc_clip_win_ctr.sv
// Loadable down-counter gated by ce; a zero load value becomes 1.
// o_tc flags the final counted cycle (count == 1).
module adc_clip_win_ctr
  import adc_clip_pkg::*;
#(
  parameter int unsigned WIN_WIDTH = DEF_WIN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ce,
  input  logic                 i_load,
  input  logic [WIN_WIDTH-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_tc
);

  logic [WIN_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_ce) begin
      if (i_load) begin
        r_cnt <= (i_load_val == '0) ? WIN_WIDTH'(1) : i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
        r_cnt <= r_cnt - WIN_WIDTH'(1);
      end
    end
  end

  assign o_tc = (r_cnt == WIN_WIDTH'(1));

endmodule

// File: rtl/adc_clip_monitor.sv
// Windowed clip-event supervisor for adc_clipping_detector.
// Define ADC_CLIP_PEAK_EN to add the cnt_peak output (max count since reset/alarm_clr).
module adc_clip_monitor
  import adc_clip_pkg::*;
#(
  parameter int unsigned WIN_WIDTH  = DEF_WIN_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 en,
  input  logic [WIN_WIDTH-1:0] win_len,
  input  logic [CNT_WIDTH-1:0] thresh,
  input  logic                 alarm_clr,
  input  logic                 clip_in,
  output logic                 det_rst,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 cnt_valid,
  output logic                 alarm
`ifdef ADC_CLIP_PEAK_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_peak
`endif
);

  localparam int unsigned      BLK_W    = $clog2(CLR_CYCLES + 1);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(CLR_CYCLES);

  clip_mon_state_t      r_state;
  logic                 r_det_rst;
  logic                 r_cnt_valid;
  logic                 r_alarm;
  logic [CNT_WIDTH-1:0] r_evt_cnt;
  logic [CNT_WIDTH-1:0] r_cnt_out;

  logic w_win_tc, w_win_load, w_win_dec;
  logic w_blk_tc, w_blk_load, w_blk_dec;
  logic w_alarm_hit;

  // Blank counter times both CLEAR and BLANK; it is reloaded on entry to either.
  always_comb begin
    w_win_load  = (r_state == CLEAR) && w_blk_tc;
    w_win_dec   = (r_state == RUN) || (r_state == BLANK);
    w_blk_load  = (((r_state == IDLE) || (r_state == REPORT)) && en) ||
                  ((r_state == RUN) && clip_in && !w_win_tc);
    w_blk_dec   = (r_state == CLEAR) || (r_state == BLANK);
    w_alarm_hit = (thresh != '0) && (r_evt_cnt >= thresh);
  end

  adc_clip_win_ctr #(.WIN_WIDTH(WIN_WIDTH)) u_win_ctr (
    .clk        (clk),
    .rst_n      (rst),
    .i_ce       (ce),
    .i_load     (w_win_load),
    .i_load_val (win_len),
    .i_dec      (w_win_dec),
    .o_tc       (w_win_tc)
  );

  adc_clip_win_ctr #(.WIN_WIDTH(BLK_W)) u_blk_ctr (
    .clk        (clk),
    .rst_n      (rst),
    .i_ce       (ce),
    .i_load     (w_blk_load),
    .i_load_val (BLK_LOAD),
    .i_dec      (w_blk_dec),
    .o_tc       (w_blk_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_det_rst   <= 1'b1;
      r_cnt_valid <= 1'b0;
      r_alarm     <= 1'b0;
      r_evt_cnt   <= '0;
      r_cnt_out   <= '0;
    end else begin
      r_cnt_valid <= 1'b0;
      // alarm_clr acts on any clk edge; a coincident REPORT set below overrides it
      if (alarm_clr) r_alarm <= 1'b0;
      if (ce) begin
        unique case (r_state)
          IDLE: begin
            if (en) r_state <= CLEAR;
          end
          CLEAR: begin
            if (!en) begin
              r_state <= IDLE;
            end else if (w_blk_tc) begin
              r_state   <= RUN;
              r_det_rst <= 1'b0;
              r_evt_cnt <= '0;
            end
          end
          RUN: begin
            if (clip_in && (r_evt_cnt != '1)) r_evt_cnt <= r_evt_cnt + CNT_WIDTH'(1);
            if (!en) begin
              r_state   <= IDLE;
              r_det_rst <= 1'b1;
            end else if (w_win_tc) begin
              r_state   <= REPORT;
              r_det_rst <= 1'b1;
            end else if (clip_in) begin
              r_state   <= BLANK;
              r_det_rst <= 1'b1;
            end
          end
          BLANK: begin
            if (!en) begin
              r_state <= IDLE;
            end else if (w_win_tc) begin
              r_state <= REPORT;
            end else if (w_blk_tc) begin
              r_state   <= RUN;
              r_det_rst <= 1'b0;
            end
          end
          REPORT: begin
            r_cnt_out   <= r_evt_cnt;
            r_cnt_valid <= 1'b1;
            if (w_alarm_hit) r_alarm <= 1'b1;
            r_state <= en ? CLEAR : IDLE;
          end
          default: begin
            r_state   <= IDLE;
            r_det_rst <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef ADC_CLIP_PEAK_EN
  logic [CNT_WIDTH-1:0] r_cnt_peak;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_peak <= '0;
    end else if (ce && (r_state == REPORT)) begin
      if (alarm_clr || (r_evt_cnt > r_cnt_peak)) r_cnt_peak <= r_evt_cnt;
    end else if (alarm_clr) begin
      r_cnt_peak <= '0;
    end
  end

  assign cnt_peak = r_cnt_peak;
`endif

  assign det_rst   = r_det_rst;
  assign cnt_out   = r_cnt_out;
  assign cnt_valid = r_cnt_valid;
  assign alarm     = r_alarm;

endmodule
